// File: rtl/z_seq_detector.sv
// z_seq_detector: watches the serial z stream for PATTERN, pulses match, keeps a saturating match count.
// Define ZSEQ_TIMEOUT_EN to build the idle counter that flushes history after TIMEOUT idle cycles.
module z_seq_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8,
    parameter int                 TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             overflow,
    output logic [4:0]       fill
);

    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } state_t;

    localparam logic [4:0]       FULL    = 5'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_reg, state_next;
    logic [PAT_LEN-1:0] hist_reg, hist_next, hist_shift;
    logic [4:0]         fill_reg, fill_next, fill_inc;
    logic               match_reg, match_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               ovf_reg, ovf_next;
    logic               hit;
    logic               idle_expire;

    // Out-of-range configurations leave this marker block in the elaborated hierarchy.
    if (PAT_LEN < 2 || PAT_LEN > 16 || CNT_W < 1 || TIMEOUT < 1) begin : g_param_out_of_range
    end

    // Shifted history: bit 0 takes the newest sample, older bits move toward the MSB.
    for (genvar gi = 0; gi < PAT_LEN; gi++) begin : g_shift
        if (gi == 0) begin : g_newest
            assign hist_shift[gi] = in_bit;
        end else begin : g_older
            assign hist_shift[gi] = hist_reg[gi-1];
        end
    end

    // Once ARMED the window stays full, so the increment saturates at PAT_LEN.
    assign fill_inc = (state_reg == ARMED) ? FULL : fill_reg + 5'd1;
    assign hit      = (fill_inc == FULL) && (hist_shift == PATTERN);

`ifdef ZSEQ_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_reg, idle_next;

    always_comb begin
        idle_next   = idle_reg;
        idle_expire = 1'b0;
        if (clear || in_valid) begin
            idle_next = '0;
        end else if (idle_reg == IDLE_W'(TIMEOUT - 1)) begin
            idle_expire = 1'b1;
            idle_next   = '0;
        end else begin
            idle_next = idle_reg + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_reg <= '0;
        end else begin
            idle_reg <= idle_next;
        end
    end
`else
    assign idle_expire = 1'b0;
`endif

    always_comb begin
        hist_next  = hist_reg;
        fill_next  = fill_reg;
        match_next = 1'b0;
        count_next = count_reg;
        ovf_next   = ovf_reg;
        if (clear) begin
            hist_next  = '0;
            fill_next  = '0;
            count_next = '0;
            ovf_next   = 1'b0;
        end else if (in_valid) begin
            hist_next = hist_shift;
            fill_next = fill_inc;
            if (hit) begin
                match_next = 1'b1;
                if (count_reg == CNT_MAX) begin
                    ovf_next = 1'b1;
                end else begin
                    count_next = count_reg + CNT_W'(1);
                end
                // Non-overlapping mode restarts the window so no bit is reused.
                if (!OVERLAP) begin
                    hist_next = '0;
                    fill_next = '0;
                end
            end
        end else if (idle_expire) begin
            hist_next = '0;
            fill_next = '0;
        end
        state_next = (fill_next == FULL) ? ARMED : FILLING;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FILLING;
            hist_reg  <= '0;
            fill_reg  <= '0;
            match_reg <= 1'b0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            hist_reg  <= hist_next;
            fill_reg  <= fill_next;
            match_reg <= match_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign match       = match_reg;
    assign match_count = count_reg;
    assign overflow    = ovf_reg;
    assign fill        = fill_reg;

endmodule
